// File: rtl/div_iter_param_pkg.sv
// Shared encodings for the iterative divider: FSM states, handshake levels, result packing.
// No logic; imported by the divider and its interface users.
package div_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE  = 2'd0,
    DIV_CALC  = 2'd1,
    DIV_FIXUP = 2'd2,
    DIV_DONE  = 2'd3
  } div_state_e;

  localparam logic DIV_START     = 1'b1;
  localparam logic DIV_STOP      = 1'b0;
  localparam logic DIV_READY     = 1'b1;
  localparam logic DIV_NOT_READY = 1'b0;

  // Upper half of result_o feeds HI (remainder), lower half feeds LO (quotient).
  localparam bit DIV_HI_IS_REM = 1'b1;

endpackage

// File: rtl/div_iter_param_if.sv
// EX-stage <-> divider bundle: operands and start/annul in, {rem,quo}/ready/dbz/busy out.
// master = EX pipeline side, slave = divider.
interface div_iter_param_if #(
  parameter int WIDTH = 32
);
  logic                 signed_div_i;
  logic [WIDTH-1:0]     opdata1_i;
  logic [WIDTH-1:0]     opdata2_i;
  logic                 start_i;
  logic                 annul_i;
  logic [2*WIDTH-1:0]   result_o;
  logic                 ready_o;
  logic                 dbz_o;
  logic                 busy_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o, dbz_o, busy_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o, dbz_o, busy_o
  );
endinterface

// File: rtl/div_iter_param_lzc.sv
// Leading-zero counter, purely combinational (0 cycles); all-zero input returns WIDTH.
// No handshake: output follows input every cycle.
module div_lzc #(
  parameter int WIDTH = 32,
  parameter int CW    = $clog2(WIDTH) + 1
) (
  input  logic [WIDTH-1:0] i_dat,
  output logic [CW-1:0]    o_cnt
);

  // Scan LSB to MSB so the highest set bit is the last one to win.
  always_comb begin
    o_cnt = CW'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (i_dat[i]) begin
        o_cnt = CW'(WIDTH - 1 - i);
      end
    end
  end

endmodule

// File: rtl/div_iter_param.sv
// Radix-2 restoring divider, WIDTH-skip+2 edges from accept to ready (1 edge on zero divisor).
// Result held while start_i stays high; annul_i aborts CALC/FIXUP, ignored in DONE.
module div_iter_param
  import div_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter bit EARLY_OUT = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  div_iter_param_if.slave bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  div_state_e         r_state, w_nxt_state;
  logic [CW-1:0]      r_cnt, w_nxt_cnt, w_skip;
  logic [2*WIDTH-1:0] r_work, w_nxt_work;
  logic [2*WIDTH-1:0] r_result, w_nxt_result;
  logic [WIDTH-1:0]   r_b, w_nxt_b;
  logic [WIDTH-1:0]   w_a_mag, w_b_mag, w_diff, w_quo, w_rem;
  logic [WIDTH:0]     w_trial;
  logic               w_ge, w_accept;
  logic               r_signed, r_neg_a, r_neg_b;
  logic               w_nxt_signed, w_nxt_neg_a, w_nxt_neg_b;
  logic               r_ready, w_nxt_ready, r_dbz, w_nxt_dbz;

  // MIN negates to itself, which reads correctly as an unsigned magnitude.
  assign w_a_mag = (bus.signed_div_i && bus.opdata1_i[WIDTH-1]) ? -bus.opdata1_i : bus.opdata1_i;
  assign w_b_mag = (bus.signed_div_i && bus.opdata2_i[WIDTH-1]) ? -bus.opdata2_i : bus.opdata2_i;
  assign w_accept = (bus.start_i == DIV_START) && !bus.annul_i;

  generate
    if (EARLY_OUT) begin : g_lzc
      div_lzc #(.WIDTH(WIDTH)) u_lzc (
        .i_dat (w_a_mag),
        .o_cnt (w_skip)
      );
    end else begin : g_no_lzc
      assign w_skip = '0;
    end
  endgenerate

  // Partial remainder plus next dividend bit needs WIDTH+1 bits; the difference fits in WIDTH.
  assign w_trial = r_work[2*WIDTH-1:WIDTH-1];
  assign w_ge    = (w_trial >= {1'b0, r_b});
  assign w_diff  = w_trial[WIDTH-1:0] - r_b;

  assign w_quo = (r_signed && (r_neg_a ^ r_neg_b)) ? -r_work[WIDTH-1:0] : r_work[WIDTH-1:0];
  assign w_rem = (r_signed && r_neg_a) ? -r_work[2*WIDTH-1:WIDTH] : r_work[2*WIDTH-1:WIDTH];

  always_comb begin
    w_nxt_state  = r_state;
    w_nxt_cnt    = r_cnt;
    w_nxt_work   = r_work;
    w_nxt_b      = r_b;
    w_nxt_signed = r_signed;
    w_nxt_neg_a  = r_neg_a;
    w_nxt_neg_b  = r_neg_b;
    w_nxt_result = r_result;
    w_nxt_ready  = r_ready;
    w_nxt_dbz    = r_dbz;
    unique case (r_state)
      DIV_IDLE: begin
        w_nxt_result = '0;
        w_nxt_ready  = DIV_NOT_READY;
        w_nxt_dbz    = 1'b0;
        if (w_accept) begin
          w_nxt_signed = bus.signed_div_i;
          w_nxt_neg_a  = bus.opdata1_i[WIDTH-1];
          w_nxt_neg_b  = bus.opdata2_i[WIDTH-1];
          w_nxt_b      = w_b_mag;
          if (bus.opdata2_i == '0) begin
            w_nxt_ready = DIV_READY;
            w_nxt_dbz   = 1'b1;
            w_nxt_state = DIV_DONE;
          end else begin
            w_nxt_work  = {{WIDTH{1'b0}}, w_a_mag << w_skip};
            w_nxt_cnt   = w_skip;
            w_nxt_state = (w_skip < CW'(WIDTH)) ? DIV_CALC : DIV_FIXUP;
          end
        end
      end
      DIV_CALC: begin
        if (bus.annul_i) begin
          w_nxt_state = DIV_IDLE;
        end else begin
          w_nxt_work = w_ge ? {w_diff, r_work[WIDTH-2:0], 1'b1}
                            : {r_work[2*WIDTH-2:0], 1'b0};
          w_nxt_cnt  = r_cnt + 1'b1;
          if (r_cnt == CW'(WIDTH - 1)) begin
            w_nxt_state = DIV_FIXUP;
          end
        end
      end
      DIV_FIXUP: begin
        if (bus.annul_i) begin
          w_nxt_state = DIV_IDLE;
        end else begin
          w_nxt_result = DIV_HI_IS_REM ? {w_rem, w_quo} : {w_quo, w_rem};
          w_nxt_ready  = DIV_READY;
          w_nxt_state  = DIV_DONE;
        end
      end
      DIV_DONE: begin
        if (bus.start_i == DIV_STOP) begin
          w_nxt_result = '0;
          w_nxt_ready  = DIV_NOT_READY;
          w_nxt_dbz    = 1'b0;
          w_nxt_state  = DIV_IDLE;
        end
      end
      default: w_nxt_state = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= DIV_IDLE;
      r_cnt    <= '0;
      r_work   <= '0;
      r_b      <= '0;
      r_signed <= 1'b0;
      r_neg_a  <= 1'b0;
      r_neg_b  <= 1'b0;
      r_result <= '0;
      r_ready  <= DIV_NOT_READY;
      r_dbz    <= 1'b0;
    end else begin
      r_state  <= w_nxt_state;
      r_cnt    <= w_nxt_cnt;
      r_work   <= w_nxt_work;
      r_b      <= w_nxt_b;
      r_signed <= w_nxt_signed;
      r_neg_a  <= w_nxt_neg_a;
      r_neg_b  <= w_nxt_neg_b;
      r_result <= w_nxt_result;
      r_ready  <= w_nxt_ready;
      r_dbz    <= w_nxt_dbz;
    end
  end

  assign bus.result_o = r_result;
  assign bus.ready_o  = r_ready;
  assign bus.dbz_o    = r_dbz;
  assign bus.busy_o   = (r_state == DIV_CALC) || (r_state == DIV_FIXUP);

endmodule

// File: tb/tb_div_iter_param.sv
// Drives three divider instances (32-bit, 32-bit early-out, 8-bit) against an arithmetic model.
module tb_div_iter_param;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  div_iter_param_if #(.WIDTH(32)) bus0 ();
  div_iter_param_if #(.WIDTH(32)) bus1 ();
  div_iter_param_if #(.WIDTH(8))  bus2 ();

  div_iter_param #(.WIDTH(32), .EARLY_OUT(1'b0)) u_div0 (.clk(clk), .rst(rst), .bus(bus0));
  div_iter_param #(.WIDTH(32), .EARLY_OUT(1'b1)) u_div1 (.clk(clk), .rst(rst), .bus(bus1));
  div_iter_param #(.WIDTH(8),  .EARLY_OUT(1'b0)) u_div2 (.clk(clk), .rst(rst), .bus(bus2));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_ops(input int inst, input bit sgn, input logic [63:0] a, input logic [63:0] b);
    case (inst)
      0: begin bus0.signed_div_i = sgn; bus0.opdata1_i = a[31:0]; bus0.opdata2_i = b[31:0]; end
      1: begin bus1.signed_div_i = sgn; bus1.opdata1_i = a[31:0]; bus1.opdata2_i = b[31:0]; end
      default: begin bus2.signed_div_i = sgn; bus2.opdata1_i = a[7:0]; bus2.opdata2_i = b[7:0]; end
    endcase
  endtask

  task automatic set_ctl(input int inst, input bit st, input bit an);
    case (inst)
      0: begin bus0.start_i = st; bus0.annul_i = an; end
      1: begin bus1.start_i = st; bus1.annul_i = an; end
      default: begin bus2.start_i = st; bus2.annul_i = an; end
    endcase
  endtask

  function automatic logic [127:0] get_res(input int inst);
    case (inst)
      0: return {64'b0, bus0.result_o};
      1: return {64'b0, bus1.result_o};
      default: return {112'b0, bus2.result_o};
    endcase
  endfunction

  // {busy, dbz, ready}
  function automatic logic [2:0] get_flags(input int inst);
    case (inst)
      0: return {bus0.busy_o, bus0.dbz_o, bus0.ready_o};
      1: return {bus1.busy_o, bus1.dbz_o, bus1.ready_o};
      default: return {bus2.busy_o, bus2.dbz_o, bus2.ready_o};
    endcase
  endfunction

  // Reference: plain integer division, then latency from the dividend magnitude.
  function automatic void model(input int w, input bit eo, input bit sgn,
                                input logic [63:0] a_in, input logic [63:0] b_in,
                                output logic [127:0] res, output int lat, output bit dbz);
    logic [63:0] mask, a, b, q, r, mag;
    longint sa, sb;
    int skip;
    mask = (64'd1 << w) - 64'd1;
    a = a_in & mask;
    b = b_in & mask;
    if (b == 64'd0) begin
      res = '0; lat = 1; dbz = 1'b1;
      return;
    end
    dbz = 1'b0;
    if (sgn) begin
      sa = longint'(a);
      sb = longint'(b);
      if (a[w-1]) sa = sa - (longint'(1) << w);
      if (b[w-1]) sb = sb - (longint'(1) << w);
      q = 64'(sa / sb) & mask;
      r = 64'(sa % sb) & mask;
      mag = (sa < 0) ? 64'(-sa) : 64'(sa);
    end else begin
      q = a / b;
      r = a % b;
      mag = a;
    end
    skip = 0;
    if (eo) begin
      while (skip < w && !mag[w-1-skip]) skip++;
    end
    lat = w - skip + 2;
    res = (128'(r) << w) | 128'(q);
  endfunction

  task automatic run_op(input int inst, input bit sgn, input logic [63:0] a,
                        input logic [63:0] b, input bit scramble);
    int w, exp_lat, k;
    bit eo, exp_dbz;
    logic [127:0] exp_res;
    logic [2:0] f;
    w  = (inst == 2) ? 8 : 32;
    eo = (inst == 1);
    model(w, eo, sgn, a, b, exp_res, exp_lat, exp_dbz);
    set_ops(inst, sgn, a, b);
    set_ctl(inst, 1'b1, 1'b0);
    k = 0;
    f = '0;
    while (k < 200 && !f[0]) begin
      @(posedge clk); #1;
      k++;
      f = get_flags(inst);
      if (k == 1) begin
        chk("busy_after_accept", 128'(f[2]), 128'(!exp_dbz));
        if (scramble) set_ops(inst, 1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom});
      end
    end
    chk("latency", 128'(k), 128'(exp_lat));
    chk("result", get_res(inst), exp_res);
    chk("dbz", 128'(f[1]), 128'(exp_dbz));
    set_ctl(inst, 1'b1, 1'b1);
    @(posedge clk); #1;
    f = get_flags(inst);
    chk("hold_result", get_res(inst), exp_res);
    chk("hold_flags", 128'(f), {125'b0, 1'b0, exp_dbz, 1'b1});
    set_ctl(inst, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("release_flags", 128'(get_flags(inst)), 128'(0));
    chk("release_result", get_res(inst), 128'(0));
  endtask

  initial begin
    logic [2:0] f;
    logic [63:0] ra, rb;
    bit seen;
    int k;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_ops(i, 1'b0, 64'd0, 64'd0);
      set_ctl(i, 1'b0, 1'b0);
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("reset_flags", 128'(get_flags(i)), 128'(0));
      chk("reset_result", get_res(i), 128'(0));
    end
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed 32-bit cases
    run_op(0, 1'b0, 64'd100, 64'd7, 1'b0);
    run_op(0, 1'b1, 64'hFFFF_FFF9, 64'd2, 1'b1);
    run_op(0, 1'b1, 64'd7, 64'hFFFF_FFFE, 1'b1);
    run_op(0, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 1'b1);
    run_op(0, 1'b0, 64'hFFFF_FFFF, 64'h10, 1'b0);
    run_op(0, 1'b0, 64'h1234_5678, 64'd0, 1'b0);
    run_op(0, 1'b1, 64'h8765_4321, 64'd0, 1'b1);
    run_op(0, 1'b0, 64'hFFFF_FFFF, 64'h8000_0001, 1'b0);

    // Annul mid-CALC: no ready afterwards, then a clean op
    set_ops(0, 1'b0, 64'd100000, 64'd3);
    set_ctl(0, 1'b1, 1'b0);
    repeat (11) @(posedge clk);
    #1;
    f = get_flags(0);
    chk("annul_pre_busy", 128'(f[2]), 128'(1));
    set_ctl(0, 1'b0, 1'b1);
    @(posedge clk); #1;
    chk("annul_idle_flags", 128'(get_flags(0)), 128'(0));
    set_ctl(0, 1'b0, 1'b0);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      f = get_flags(0);
      seen = seen | f[0];
    end
    chk("annul_no_ready", 128'(seen), 128'(0));
    run_op(0, 1'b0, 64'd9, 64'd3, 1'b0);

    // start with annul in IDLE must not accept
    set_ops(0, 1'b0, 64'd50, 64'd5);
    set_ctl(0, 1'b1, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("annul_blocks_accept", 128'(get_flags(0)), 128'(0));
    set_ctl(0, 1'b0, 1'b0);
    @(posedge clk); #1;

    // Reset mid-CALC and reset in DONE
    set_ops(0, 1'b1, -64'sd1000, 64'd7);
    set_ctl(0, 1'b1, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    f = get_flags(0);
    chk("rst_calc_busy", 128'(f[2]), 128'(1));
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_calc_flags", 128'(get_flags(0)), 128'(0));
    chk("rst_calc_result", get_res(0), 128'(0));
    rst = 1'b0;
    set_ops(0, 1'b0, 64'd50, 64'd5);
    k = 0;
    f = '0;
    while (k < 60 && !f[0]) begin
      @(posedge clk); #1;
      k++;
      f = get_flags(0);
    end
    chk("rst_done_pre_result", get_res(0), {64'b0, 32'd0, 32'd10});
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_done_flags", 128'(get_flags(0)), 128'(0));
    chk("rst_done_result", get_res(0), 128'(0));
    rst = 1'b0;
    set_ctl(0, 1'b0, 1'b0);
    @(posedge clk); #1;

    // Early-out instance
    run_op(1, 1'b0, 64'd5, 64'd3, 1'b0);
    run_op(1, 1'b0, 64'd0, 64'd3, 1'b0);
    run_op(1, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 1'b1);
    run_op(1, 1'b0, 64'hFFFF_FFFF, 64'h10, 1'b0);

    // 8-bit instance
    run_op(2, 1'b0, 64'd200, 64'd9, 1'b0);
    run_op(2, 1'b1, 64'h80, 64'hFF, 1'b1);

    // Random mix across all instances
    for (int n = 0; n < 45; n++) begin
      ra = 64'($urandom) >> $urandom_range(0, 31);
      rb = 64'($urandom) >> $urandom_range(0, 31);
      if ($urandom_range(0, 7) == 0) rb = 64'd0;
      run_op(n % 3, 1'($urandom_range(0, 1)), ra, rb, 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
